// File: rtl/seg7_pkg.sv
// Shared constants and types for the result display: segment codes,
// digit counts, converter state encoding and the BCD-to-segment lookup.
package seg7_pkg;

    localparam int NUM_BCD    = 5;
    localparam int NUM_DIGITS = 8;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} conv_state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = SEG_0;
            4'd1:    seg_of = SEG_1;
            4'd2:    seg_of = SEG_2;
            4'd3:    seg_of = SEG_3;
            4'd4:    seg_of = SEG_4;
            4'd5:    seg_of = SEG_5;
            4'd6:    seg_of = SEG_6;
            4'd7:    seg_of = SEG_7;
            4'd8:    seg_of = SEG_8;
            4'd9:    seg_of = SEG_9;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, 16 shifts per value,
// with a single latest-wins pending slot so strobes during a conversion are kept.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        cpu_reset,
    input  logic [15:0] bin,
    input  logic        start,
    output logic [19:0] bcd,
    output logic        done,
    output logic        busy
);

    conv_state_t state, state_nxt;
    logic [15:0] sh_bin;
    logic [19:0] sh_bcd;
    logic [19:0] adj;
    logic [3:0]  cnt;
    logic [15:0] pend_val;
    logic        pend;

    always_comb begin
        adj = sh_bcd;
        for (int i = 0; i < NUM_BCD; i++)
            if (sh_bcd[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = sh_bcd[i*4 +: 4] + 4'd3;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONVERT;
            CONVERT: if (cnt == 4'd15) state_nxt = COMMIT;
            COMMIT:  state_nxt = (start || pend) ? CONVERT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            sh_bin   <= '0;
            sh_bcd   <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_val <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sh_bin <= bin;
                    sh_bcd <= '0;
                    cnt    <= '0;
                end
                CONVERT: begin
                    {sh_bcd, sh_bin} <= {adj, sh_bin} << 1;
                    cnt <= cnt + 4'd1;
                    if (start) begin
                        pend     <= 1'b1;
                        pend_val <= bin;
                    end
                end
                COMMIT: if (start || pend) begin
                    // a strobe landing on the commit cycle is newer than the pending slot
                    sh_bin <= start ? bin : pend_val;
                    sh_bcd <= '0;
                    cnt    <= '0;
                    pend   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bcd  = sh_bcd;
    assign done = (state == COMMIT);
    assign busy = (state != IDLE);

endmodule

// File: rtl/result_display.sv
// Output stage: converts the integrator result to decimal and scans it onto an
// 8-digit multiplexed seven-segment display, right-aligned, with an "Err" override.
module result_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  cpu_reset,
    input  logic [15:0]           result,
    input  logic                  result_valid,
    input  logic                  err,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [6:0]            segments,
    output logic                  busy
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]               presc;
    logic [IW-1:0]               idx;
    logic [NUM_BCD-1:0][3:0]     digits;
    logic [NUM_BCD-1:0]          nz;
    logic [19:0]                 bcd;
    logic                        done;
    logic [6:0]                  seg_nxt;

    bin2bcd_seq u_conv (
        .clk       (clk),
        .cpu_reset (cpu_reset),
        .bin       (result),
        .start     (result_valid),
        .bcd       (bcd),
        .done      (done),
        .busy      (busy)
    );

    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset)  digits <= '0;
        else if (done)   digits <= bcd;
    end

    // nz[k]: some digit at position k or above is nonzero, so digit k is not a leading zero
    for (genvar k = 0; k < NUM_BCD; k++) begin : g_nz
        assign nz[k] = |digits[NUM_BCD-1:k];
    end

    always_comb begin
        seg_nxt = SEG_BLANK;
        if (err) begin
            case (idx)
                IW'(2):        seg_nxt = SEG_E;
                IW'(1), IW'(0): seg_nxt = SEG_R;
                default:       seg_nxt = SEG_BLANK;
            endcase
        end else if (idx == IW'(0)) begin
            seg_nxt = seg_of(digits[0]);
        end else begin
            for (int k = 1; k < NUM_BCD; k++)
                if (idx == IW'(k) && nz[k])
                    seg_nxt = seg_of(digits[k]);
        end
    end

    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            anodes   <= 8'hFE;
            segments <= SEG_0;
        end else begin
            anodes   <= ~(NUM_DIGITS'(1) << idx);
            segments <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: a cycle-level timeline model of the
// converter plus arithmetic digit extraction predicts every anode/segment/busy value.
module tb_result_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        cpu_reset = 1'b1;
    logic [15:0] result = '0;
    logic        result_valid = 1'b0;
    logic        err = 1'b0;
    logic [7:0]  anodes;
    logic [6:0]  segments;
    logic        busy;

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clk          (clk),
        .cpu_reset    (cpu_reset),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .anodes       (anodes),
        .segments     (segments),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: edges since reset release, shown value, value in flight, pending slot
    int  cyc = 0;
    int  disp = 0;
    bit  conv = 0;
    int  cur = 0;
    int  commit_at = 0;
    bit  pend = 0;
    int  pend_val = 0;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic [6:0] codes [10];

    typedef struct {
        logic [15:0]     value;
        logic            err;
        logic [7:0][6:0] seg;
    } vec_t;
    vec_t tbl [7];

    function automatic logic [6:0] model_seg(input int k, input int v, input bit e);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (e) return (k == 2) ? 7'h06 : ((k < 2) ? 7'h2F : 7'h7F);
        if (k > 0 && v < p) return 7'h7F;
        return codes[(v / p) % 10];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit sv, input logic [15:0] rv, input bit ev);
        int k;
        result_valid = sv;
        result = rv;
        err = ev;
        @(posedge clk);
        cyc++;
        k = ((cyc - 1) / DIV) % 8;
        exp_an = ~(8'd1 << k);
        exp_seg = model_seg(k, disp, ev);
        if (conv && cyc == commit_at) begin
            disp = cur;
            if (sv || pend) begin
                cur = sv ? int'(rv) : pend_val;
                commit_at = cyc + 17;
                pend = 0;
            end else begin
                conv = 0;
            end
        end else if (conv && sv) begin
            pend = 1;
            pend_val = int'(rv);
        end else if (!conv && sv) begin
            conv = 1;
            cur = int'(rv);
            commit_at = cyc + 17;
        end
        @(negedge clk);
        chk("anodes", 32'(anodes), 32'(exp_an));
        chk("segments", 32'(segments), 32'(exp_seg));
        chk("busy", 32'(busy), 32'(conv));
    endtask

    task automatic do_reset();
        cpu_reset = 1'b0;
        result_valid = 1'b0;
        err = 1'b0;
        #1;
        chk("rst_anodes", 32'(anodes), 32'h0FE);
        chk("rst_segments", 32'(segments), 32'h040);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        cyc = 0; disp = 0; conv = 0; pend = 0;
        cpu_reset = 1'b1;
    endtask

    task automatic wait_slot0();
        int guard = 0;
        while (anodes !== 8'hFE && guard < 40) begin
            step(1'b0, 16'd0, 1'b0);
            guard++;
        end
        chk("slot0_wait", 32'(guard < 40), 32'd1);
    endtask

    initial begin
        int n;
        bit ev;
        logic [15:0] v;
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        // segments listed idx7 .. idx0
        tbl[0] = '{16'd52,    1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h12,7'h24}};
        tbl[1] = '{16'd10681, 1'b0, {7'h7F,7'h7F,7'h7F,7'h79,7'h40,7'h02,7'h00,7'h79}};
        tbl[2] = '{16'd65535, 1'b0, {7'h7F,7'h7F,7'h7F,7'h02,7'h12,7'h12,7'h30,7'h12}};
        tbl[3] = '{16'd0,     1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}};
        tbl[4] = '{16'd9,     1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h10}};
        tbl[5] = '{16'd100,   1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h40,7'h40}};
        tbl[6] = '{16'd52,    1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h06,7'h2F,7'h2F}};

        #2;
        do_reset();
        repeat (36) step(1'b0, 16'd0, 1'b0);

        // busy width for a single value
        step(1'b1, 16'd52, 1'b0);
        n = 0;
        for (int t = 0; t < 40; t++) begin
            if (busy) n++;
            step(1'b0, 16'd0, 1'b0);
        end
        chk("busy_len_single", 32'(n), 32'd17);

        // table vectors: strobe, let it settle, then scan every slot
        for (int i = 0; i < 7; i++) begin
            step(1'b1, tbl[i].value, tbl[i].err);
            repeat (19) step(1'b0, 16'd0, tbl[i].err);
            for (int t = 0; t < 34; t++) begin
                step(1'b0, 16'd0, tbl[i].err);
                chk("table_seg", 32'(segments), 32'(tbl[i].seg[((cyc - 1) / DIV) % 8]));
            end
        end
        // err released: number back on the next output update
        step(1'b0, 16'd0, 1'b0);
        wait_slot0();
        chk("err_release_d0", 32'(segments), 32'h024);

        // back-to-back strobes with latest-wins pending
        n = 0;
        for (int t = 0; t < 60; t++) begin
            step(t == 0 || t == 3 || t == 10,
                 (t == 0) ? 16'd93 : ((t == 3) ? 16'd125 : 16'd7), 1'b0);
            if (busy) n++;
        end
        chk("busy_len_b2b", 32'(n), 32'd34);
        wait_slot0();
        chk("b2b_final_d0", 32'(segments), 32'h078);

        // same sequence, reset hits before E8
        for (int t = 0; t < 8; t++)
            step(t == 0 || t == 3, (t == 0) ? 16'd93 : 16'd125, 1'b0);
        do_reset();
        repeat (60) step(1'b0, 16'd0, 1'b0);
        chk("after_rst_busy", 32'(busy), 32'd0);

        // random traffic against the model
        ev = 0;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 39) == 0) ev = ~ev;
            v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 99))
                                            : 16'($urandom_range(0, 65535));
            step($urandom_range(0, 11) == 0, v, ev);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
